// File: rtl/rf_bank_pkg.sv
// rtl/rf_bank_pkg.sv - shared types and defaults for the rf_bank register file
package rf_bank_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_t;

  // Per-register write-back source
  typedef enum logic [1:0] {
    WB_HOLD  = 2'd0,
    WB_PORT0 = 2'd1,
    WB_PORT1 = 2'd2,
    WB_ZERO  = 2'd3
  } wb_sel_t;

  // Sweep zeroing beats port 1, which beats port 0
  function automatic wb_sel_t wb_select(input logic zero_hit, input logic w1_hit,
                                        input logic w0_hit);
    if (zero_hit)    return WB_ZERO;
    else if (w1_hit) return WB_PORT1;
    else if (w0_hit) return WB_PORT0;
    else             return WB_HOLD;
  endfunction

endpackage

// File: rtl/rf_bank_if.sv
// rtl/rf_bank_if.sv - read/write/scoreboard/clear bundle for rf_bank
interface rf_bank_if #(
  parameter int XLEN = rf_bank_pkg::XLEN_DEF,
  parameter int NREG = rf_bank_pkg::NREG_DEF
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            we0;
  logic [AW-1:0]   waddr0;
  logic [XLEN-1:0] wdata0;
  logic            we1;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata1;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic            sb_busy1;
  logic            sb_busy2;
  logic            clr_req;
  logic            clr_busy;

  modport master (
    output raddr1, raddr2, we0, waddr0, wdata0, we1, waddr1, wdata1,
           sb_set, sb_addr, clr_req,
    input  rdata1, rdata2, sb_busy1, sb_busy2, clr_busy
  );

  modport slave (
    input  raddr1, raddr2, we0, waddr0, wdata0, we1, waddr1, wdata1,
           sb_set, sb_addr, clr_req,
    output rdata1, rdata2, sb_busy1, sb_busy2, clr_busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits; forwarding mask under RF_BYPASS_EN
module rf_scoreboard
  import rf_bank_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear_all,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_wr0,
  input  logic [AW-1:0] i_wr0_addr,
  input  logic          i_wr1,
  input  logic [AW-1:0] i_wr1_addr,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic          o_busy1,
  output logic          o_busy2
);

  logic [NREG-1:0] r_busy;

  // Set wins over a same-cycle write; a sweep start wipes everything.
  // Bit 0 is never set, so address 0 always reads not-busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else if (i_clear_all) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (i_set && (i_set_addr == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((i_wr0 && (i_wr0_addr == AW'(i))) ||
                     (i_wr1 && (i_wr1_addr == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Busy lookup, masked by a same-cycle accepted write when forwarding is built in
  always_comb begin
    o_busy1 = r_busy[i_raddr1];
    o_busy2 = r_busy[i_raddr2];
`ifdef RF_BYPASS_EN
    if ((i_wr0 && (i_wr0_addr == i_raddr1)) || (i_wr1 && (i_wr1_addr == i_raddr1))) begin
      o_busy1 = 1'b0;
    end
    if ((i_wr0 && (i_wr0_addr == i_raddr2)) || (i_wr1 && (i_wr1_addr == i_raddr2))) begin
      o_busy2 = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/rf_bank.sv
// rtl/rf_bank.sv - 2R/2W register file with scoreboard and sweep clear; RF_BYPASS_EN adds write forwarding
module rf_bank
  import rf_bank_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input logic     clk,
  input logic     rst,
  rf_bank_if.slave bus
);

  localparam int AW = $clog2(NREG);

  rf_state_t       r_state;
  rf_state_t       w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_regs [NREG];

  logic            w_accept;
  logic            w_clear_start;
  logic            w_sweep;
  logic            w_clr_busy;
  logic            w_we0;
  logic            w_we1;
  logic            w_set;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: the sweep leaves after writing the last register
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.clr_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_idx == AW'(NREG - 1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: requests are only honoured in IDLE and out of reset
  always_comb begin
    w_accept      = 1'b0;
    w_clear_start = 1'b0;
    w_sweep       = 1'b0;
    w_clr_busy    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept      = !rst;
        w_clear_start = bus.clr_req;
      end
      ST_CLEAR: begin
        w_sweep    = 1'b1;
        w_clr_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.clr_busy = w_clr_busy;
  assign w_we0 = w_accept && bus.we0 && (bus.waddr0 != '0);
  assign w_we1 = w_accept && bus.we1 && (bus.waddr1 != '0);
  assign w_set = w_accept && bus.sb_set && (bus.sb_addr != '0);

  // Sweep index: loads 1 on entry, wraps to 0 naturally on the final increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_idx <= '0;
    else if (w_clear_start) r_idx <= AW'(1);
    else if (w_sweep)       r_idx <= r_idx + AW'(1);
  end

  // Register storage; entry 0 is held at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        case (wb_select(w_sweep && (r_idx == AW'(i)),
                        w_we1 && (bus.waddr1 == AW'(i)),
                        w_we0 && (bus.waddr0 == AW'(i))))
          WB_ZERO:  r_regs[i] <= '0;
          WB_PORT1: r_regs[i] <= bus.wdata1;
          WB_PORT0: r_regs[i] <= bus.wdata0;
          default:  ;
        endcase
      end
    end
  end

  // Combinational reads, optionally forwarding accepted same-cycle writes
  always_comb begin
    w_rd1 = (bus.raddr1 == '0) ? '0 : r_regs[bus.raddr1];
    w_rd2 = (bus.raddr2 == '0) ? '0 : r_regs[bus.raddr2];
`ifdef RF_BYPASS_EN
    if (w_we1 && (bus.waddr1 == bus.raddr1))      w_rd1 = bus.wdata1;
    else if (w_we0 && (bus.waddr0 == bus.raddr1)) w_rd1 = bus.wdata0;
    if (w_we1 && (bus.waddr1 == bus.raddr2))      w_rd2 = bus.wdata1;
    else if (w_we0 && (bus.waddr0 == bus.raddr2)) w_rd2 = bus.wdata0;
`endif
  end

  assign bus.rdata1 = w_rd1;
  assign bus.rdata2 = w_rd2;

  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_clear_all(w_clear_start),
    .i_set      (w_set),
    .i_set_addr (bus.sb_addr),
    .i_wr0      (w_we0),
    .i_wr0_addr (bus.waddr0),
    .i_wr1      (w_we1),
    .i_wr1_addr (bus.waddr1),
    .i_raddr1   (bus.raddr1),
    .i_raddr2   (bus.raddr2),
    .o_busy1    (bus.sb_busy1),
    .o_busy2    (bus.sb_busy2)
  );

endmodule

// File: tb/tb_rf_bank.sv
// tb/tb_rf_bank.sv - directed bench for rf_bank; expectations follow RF_BYPASS_EN when defined
module tb_rf_bank;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  rf_bank_if #(.XLEN(32), .NREG(32)) bus ();

  rf_bank #(.XLEN(32), .NREG(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.we0     = 1'b0;
    bus.we1     = 1'b0;
    bus.sb_set  = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.raddr1 = '0; bus.raddr2 = '0;
    bus.waddr0 = '0; bus.wdata0 = '0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.sb_addr = '0;
    quiet();

    // reset state; a write attempted during reset is dropped
    bus.raddr1 = 5;
    bus.we0 = 1'b1; bus.waddr0 = 5; bus.wdata0 = 32'hFFFF;
    #1;
    chk("rst_rdata1", bus.rdata1, 32'h0);
    chk("rst_rdata2", bus.rdata2, 32'h0);
    chk("rst_busy1", bus.sb_busy1, 1'b0);
    chk("rst_busy2", bus.sb_busy2, 1'b0);
    chk("rst_clr_busy", bus.clr_busy, 1'b0);
    step();
    chk("rst_write_dropped", bus.rdata1, 32'h0);
    quiet();
    rst = 1'b0;
    #1;

    // x5 via port 0
    bus.we0 = 1'b1; bus.waddr0 = 5; bus.wdata0 = 32'hDEADBEEF;
    step(); quiet();
    bus.raddr1 = 5; #1;
    chk("x5_read", bus.rdata1, 32'hDEADBEEF);

    // x0 write and sb_set on x0 ignored
    bus.we0 = 1'b1; bus.waddr0 = 0; bus.wdata0 = 32'h1234;
    bus.sb_set = 1'b1; bus.sb_addr = 0;
    step(); quiet();
    bus.raddr1 = 0; #1;
    chk("x0_read", bus.rdata1, 32'h0);
    chk("x0_busy", bus.sb_busy1, 1'b0);

    // both ports hit x7, port 1 wins
    bus.we0 = 1'b1; bus.waddr0 = 7; bus.wdata0 = 32'h11;
    bus.we1 = 1'b1; bus.waddr1 = 7; bus.wdata1 = 32'h22;
    step(); quiet();
    bus.raddr1 = 7; #1;
    chk("x7_prio", bus.rdata1, 32'h22);

    // sb_set and write of x9 together: set wins, data still stored
    bus.sb_set = 1'b1; bus.sb_addr = 9;
    bus.we0 = 1'b1; bus.waddr0 = 9; bus.wdata0 = 32'h99;
    step(); quiet();
    bus.raddr1 = 9; bus.raddr2 = 9; #1;
    chk("x9_busy", bus.sb_busy2, 1'b1);
    chk("x9_data", bus.rdata1, 32'h99);

    // x3 pending, then cleared by a write
    bus.sb_set = 1'b1; bus.sb_addr = 3;
    step(); quiet();
    bus.raddr1 = 3; #1;
    chk("x3_busy_set", bus.sb_busy1, 1'b1);
    bus.we1 = 1'b1; bus.waddr1 = 3; bus.wdata1 = 32'h5; #1;
`ifdef RF_BYPASS_EN
    chk("x3_busy_same_cycle", bus.sb_busy1, 1'b0);
`else
    chk("x3_busy_same_cycle", bus.sb_busy1, 1'b1);
`endif
    step(); quiet(); #1;
    chk("x3_busy_cleared", bus.sb_busy1, 1'b0);
    chk("x3_data", bus.rdata1, 32'h5);

    // forwarding on x4
    bus.we0 = 1'b1; bus.waddr0 = 4; bus.wdata0 = 32'h1111;
    step(); quiet();
    bus.sb_set = 1'b1; bus.sb_addr = 4;
    step(); quiet();
    bus.raddr2 = 4;
    bus.we1 = 1'b1; bus.waddr1 = 4; bus.wdata1 = 32'hA5A5; #1;
`ifdef RF_BYPASS_EN
    chk("x4_same_cycle_data", bus.rdata2, 32'hA5A5);
    chk("x4_same_cycle_busy", bus.sb_busy2, 1'b0);
`else
    chk("x4_same_cycle_data", bus.rdata2, 32'h1111);
    chk("x4_same_cycle_busy", bus.sb_busy2, 1'b1);
`endif
    step(); quiet(); #1;
    chk("x4_next_data", bus.rdata2, 32'hA5A5);
    chk("x4_next_busy", bus.sb_busy2, 1'b0);

    // fill x1..x31, mark x12 pending
    for (int i = 1; i < 32; i++) begin
      bus.we0 = 1'b1; bus.waddr0 = 5'(i); bus.wdata0 = 32'h1000_0000 | 32'(i);
      step();
    end
    quiet();
    bus.sb_set = 1'b1; bus.sb_addr = 12;
    step(); quiet();
    bus.raddr1 = 12; #1;
    chk("x12_busy", bus.sb_busy1, 1'b1);
    chk("x12_fill", bus.rdata1, 32'h1000_000C);

    // sweep: busy wiped on entry, requests dropped while clearing
    bus.clr_req = 1'b1;
    step(); quiet(); #1;
    chk("sweep_clr_busy", bus.clr_busy, 1'b1);
    chk("sweep_busy_wiped", bus.sb_busy1, 1'b0);
    bus.we0 = 1'b1; bus.waddr0 = 2; bus.wdata0 = 32'hFFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 20;
    bus.raddr1 = 1; bus.raddr2 = 31;
    n = 0;
    while (bus.clr_busy && n < 100) begin
      step();
      n++;
      if (n == 5) begin
        chk("sweep_partial_x1", bus.rdata1, 32'h0);
        chk("sweep_partial_x31", bus.rdata2, 32'h1000_001F);
      end
    end
    quiet(); #1;
    chk("sweep_len", 32'(n), 32'd31);
    chk("sweep_done_clr_busy", bus.clr_busy, 1'b0);
    for (int i = 1; i < 32; i++) begin
      bus.raddr1 = 5'(i); #1;
      chk($sformatf("sweep_zero_x%0d", i), bus.rdata1, 32'h0);
    end
    bus.raddr2 = 20; #1;
    chk("sweep_set_dropped", bus.sb_busy2, 1'b0);

    // reset in the middle of a sweep
    bus.we0 = 1'b1; bus.waddr0 = 30; bus.wdata0 = 32'h3030;
    step(); quiet();
    bus.clr_req = 1'b1;
    step(); quiet();
    repeat (9) step();
    bus.raddr1 = 30; #1;
    chk("mid_sweep_x30", bus.rdata1, 32'h3030);
    chk("mid_sweep_clr_busy", bus.clr_busy, 1'b1);
    rst = 1'b1; #1;
    chk("abort_clr_busy", bus.clr_busy, 1'b0);
    chk("abort_x30", bus.rdata1, 32'h0);
    step();
    rst = 1'b0; #1;
    bus.we1 = 1'b1; bus.waddr1 = 8; bus.wdata1 = 32'hCAFE;
    step(); quiet();
    bus.raddr1 = 8; bus.raddr2 = 30; #1;
    chk("post_rst_write", bus.rdata1, 32'hCAFE);
    chk("post_rst_x30", bus.rdata2, 32'h0);

    // a fresh sweep after the abort still takes 31 cycles
    bus.clr_req = 1'b1;
    step(); quiet();
    n = 0;
    while (bus.clr_busy && n < 100) begin
      step();
      n++;
    end
    #1;
    chk("resweep_len", 32'(n), 32'd31);
    chk("resweep_x8", bus.rdata1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_bank.md
RF_BANK -- requirements
Module: rf_bank

Interface
REQ-001 Parameter XLEN, default 32, data width of every register.
REQ-002 Parameter NREG, default 32, register count; legal range 2 to 64, power of two.
REQ-003 Derived AW = clog2(NREG), width of every address port.
REQ-004 The interface SHALL be exactly as follows (ports listed as name, direction, width, meaning):
- clk, in, 1, clock; all state changes on the rising edge.
- rst, in, 1, reset: asynchronous, active-high.
- raddr1 / raddr2, in, AW, read addresses.
- rdata1 / rdata2, out, XLEN, read data (combinational).
- we0 / waddr0 / wdata0, in, 1 / AW / XLEN, write port 0 (low priority).
- we1 / waddr1 / wdata1, in, 1 / AW / XLEN, write port 1 (high priority).
- sb_set / sb_addr, in, 1 / AW, mark a register as pending (producer issued).
- sb_busy1 / sb_busy2, out, 1, pending status of raddr1 / raddr2.
- clr_req, in, 1, request a full register sweep to zero.
- clr_busy, out, 1, sweep in progress.

Function
REQ-005 Register 0 SHALL always read zero; writes and sb_set targeting address 0 SHALL be ignored.
REQ-006 Reads SHALL be combinational: rdataN = reg[raddrN] with zero latency.
REQ-007 A write with weN=1 SHALL update reg[waddrN] at the next rising edge.
REQ-008 When both ports write the same nonzero address in one cycle, port 1 data SHALL be stored.
REQ-009 The scoreboard SHALL hold one busy bit per register, all clear after reset.
REQ-010 sb_set SHALL set busy[sb_addr] at the next edge.
REQ-011 Any accepted write SHALL clear busy[waddr] at the next edge.
REQ-012 sb_set and a write to the same address in the same cycle SHALL leave the bit set (set wins).
REQ-013 sb_busyN SHALL equal busy[raddrN] combinationally; sb_busyN SHALL be 0 for address 0.
REQ-014 The FSM SHALL have two states: IDLE and CLEAR.
REQ-015 IDLE to CLEAR: clr_req=1 in IDLE. On that edge, all busy bits SHALL clear and the sweep index SHALL load 1.
REQ-016 In CLEAR, each cycle SHALL zero reg[index] and increment the index. After index NREG-1 is written, the FSM SHALL return to IDLE, so the sweep takes NREG-1 cycles.
REQ-017 clr_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-018 In CLEAR, we0, we1, sb_set and clr_req SHALL be ignored. Reads remain live and return partially cleared contents.
REQ-019 The sweep index SHALL wrap to 0 on exit with no extra cycle.

Reset
REQ-020 rst SHALL asynchronously zero all registers and busy bits, set the FSM to IDLE and set the index to 0.
REQ-021 Reset asserted mid-sweep SHALL abort the sweep with the same result as REQ-020.
REQ-022 Output values during and after reset: rdata1 = rdata2 = 0, sb_busy1 = sb_busy2 = 0, clr_busy = 0.

Configuration
REQ-023 The macro RF_BYPASS_EN SHALL control write-to-read forwarding.
- Defined: a read whose nonzero address matches an accepted same-cycle write SHALL return the write data (port 1 over port 0), and the matching sb_busyN SHALL read 0.
- Undefined: reads SHALL return the stored value and sb_busyN the stored bit.
REQ-024 Bypass SHALL be inactive in CLEAR and for address 0.

Structure
REQ-025 The FSM state encoding (IDLE, CLEAR) and the XLEN/NREG defaults SHALL live in the shared package alongside the write-back select constants.
REQ-026 The scoreboard SHALL be a sub-module rf_scoreboard, parametrised on NREG, containing the set/clear/priority logic and the bypass masking.

Verification
REQ-027 A directed bench SHALL cover the following scenarios (stimulus -> required response):
- Write x5=0xDEADBEEF via port 0, then read raddr1=5 -> rdata1=0xDEADBEEF next cycle. Write x0=0x1234 -> rdata of 0 stays 0.
- Same cycle: we0 x7=0x11 and we1 x7=0x22 -> x7=0x22. Same cycle: sb_set x9 and write x9 -> sb_busy for x9 stays 1.
- sb_set x3 -> sb_busy1=1 for raddr1=3 -> write x3=0x5 -> sb_busy1=0 next cycle.
- Fill x1..x31 with nonzero values, pulse clr_req -> clr_busy high for 31 cycles, writes issued meanwhile are dropped, then all registers read 0.
- With RF_BYPASS_EN: we1 x4=0xA5A5 while raddr2=4 -> rdata2=0xA5A5 in the same cycle. Without the macro -> old value that cycle, 0xA5A5 the next.
- Assert rst at sweep cycle 10 -> all registers 0, clr_busy=0 immediately; after rst releases, normal writes resume.
